// File: rtl/punc_pkg.sv
// Shared definitions for the PUnC LC3 control path: opcodes, FSM states,
// control-word layout and every datapath select encoding.
package punc_pkg;

    localparam int CTRL_W = 25;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RSV8 = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RSVD = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_EXEC2,
        S_HALT
    } state_t;

    localparam logic [1:0] MEM_R_ADDR_SEL_PC       = 2'd0;
    localparam logic [1:0] MEM_R_ADDR_SEL_PCOFF9   = 2'd1;
    localparam logic [1:0] MEM_R_ADDR_SEL_BASEOFF6 = 2'd2;
    localparam logic [1:0] MEM_R_ADDR_SEL_INDIRECT = 2'd3;

    localparam logic [1:0] MEM_W_ADDR_SEL_PCOFF9   = 2'd0;
    localparam logic [1:0] MEM_W_ADDR_SEL_BASEOFF6 = 2'd1;
    localparam logic [1:0] MEM_W_ADDR_SEL_INDIRECT = 2'd2;

    localparam logic [1:0] RF_W_DATA_SEL_ALU = 2'd0;
    localparam logic [1:0] RF_W_DATA_SEL_MEM = 2'd1;
    localparam logic [1:0] RF_W_DATA_SEL_PC  = 2'd2;
    localparam logic [1:0] RF_W_DATA_SEL_LEA = 2'd3;

    localparam logic       RF_W_ADDR_SEL_DR  = 1'b0;
    localparam logic       RF_W_ADDR_SEL_R7  = 1'b1;

    // Second read port address: SR2 for ALU ops, SR (ir[11:9]) for stores.
    localparam logic       RF_R1_ADDR_SEL_SR2 = 1'b0;
    localparam logic       RF_R1_ADDR_SEL_SR  = 1'b1;

    localparam logic [1:0] PC_LD_DATA_SEL_PCOFF9  = 2'd0;
    localparam logic [1:0] PC_LD_DATA_SEL_PCOFF11 = 2'd1;
    localparam logic [1:0] PC_LD_DATA_SEL_BASE    = 2'd2;

    localparam logic [1:0] ALU_FN_ADD  = 2'd0;
    localparam logic [1:0] ALU_FN_AND  = 2'd1;
    localparam logic [1:0] ALU_FN_NOT  = 2'd2;
    localparam logic [1:0] ALU_FN_PASS = 2'd3;

    localparam logic       COND_LD_DATA_SEL_ALU = 1'b0;
    localparam logic       COND_LD_DATA_SEL_RFW = 1'b1;

    // Field order fixes the bit offsets of the control word (MSB first).
    typedef struct packed {
        logic [2:0] spare;
        logic       pc_clr;
        logic       pc_inc;
        logic       pc_ld;
        logic [1:0] pc_ld_data_sel;
        logic       ir_ld;
        logic [1:0] mem_r_addr_sel;
        logic       ptr_ld;
        logic       mem_w_en;
        logic [1:0] mem_w_addr_sel;
        logic       rf_w_en;
        logic       rf_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_r1_addr_sel;
        logic [1:0] alu_fn;
        logic       alu_imm;
        logic       cond_ld;
        logic       cond_ld_data_sel;
    } ctrl_t;

    function automatic logic is_indirect(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/punc_decode.sv
// Combinational control-word decode from FSM state, instruction and
// condition codes; holds no state of its own.
module punc_decode
    import punc_pkg::*;
(
    input  state_t      state_i,
    input  logic [15:0] ir_i,
    input  logic        n_i,
    input  logic        z_i,
    input  logic        p_i,
    output ctrl_t       ctrl_o
);

    logic [3:0] op;
    logic       br_take;
    logic       unused_ir;
    ctrl_t      c;

    assign op        = ir_i[15:12];
    assign br_take   = (ir_i[11] & n_i) | (ir_i[10] & z_i) | (ir_i[9] & p_i);
    assign unused_ir = ^{ir_i[8:6], ir_i[4:0]};

    always_comb begin
        // NOTE: the all-zero default ahead of the case keeps every field
        // assigned on every path, so no latch is inferred.
        c = '0;
        case (state_i)
            S_INIT: c.pc_clr = 1'b1;
            S_FETCH: begin
                c.mem_r_addr_sel = MEM_R_ADDR_SEL_PC;
                c.ir_ld          = 1'b1;
                c.pc_inc         = 1'b1;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_AND: begin
                        c.alu_fn           = (op == OP_AND) ? ALU_FN_AND : ALU_FN_ADD;
                        c.alu_imm          = ir_i[5];
                        c.rf_w_en          = 1'b1;
                        c.rf_w_data_sel    = RF_W_DATA_SEL_ALU;
                        c.cond_ld          = 1'b1;
                        c.cond_ld_data_sel = COND_LD_DATA_SEL_ALU;
                    end
                    OP_NOT: begin
                        c.alu_fn           = ALU_FN_NOT;
                        c.rf_w_en          = 1'b1;
                        c.rf_w_data_sel    = RF_W_DATA_SEL_ALU;
                        c.cond_ld          = 1'b1;
                        c.cond_ld_data_sel = COND_LD_DATA_SEL_ALU;
                    end
                    OP_BR: begin
                        c.pc_ld          = br_take;
                        c.pc_ld_data_sel = PC_LD_DATA_SEL_PCOFF9;
                    end
                    OP_JMP: begin
                        c.pc_ld          = 1'b1;
                        c.pc_ld_data_sel = PC_LD_DATA_SEL_BASE;
                    end
                    OP_JSR: begin
                        // Link and jump share the cycle; PC still holds the return address.
                        c.rf_w_en        = 1'b1;
                        c.rf_w_addr_sel  = RF_W_ADDR_SEL_R7;
                        c.rf_w_data_sel  = RF_W_DATA_SEL_PC;
                        c.pc_ld          = 1'b1;
                        c.pc_ld_data_sel = ir_i[11] ? PC_LD_DATA_SEL_PCOFF11
                                                    : PC_LD_DATA_SEL_BASE;
                    end
                    OP_LD, OP_LDR: begin
                        c.mem_r_addr_sel   = (op == OP_LD) ? MEM_R_ADDR_SEL_PCOFF9
                                                           : MEM_R_ADDR_SEL_BASEOFF6;
                        c.rf_w_en          = 1'b1;
                        c.rf_w_data_sel    = RF_W_DATA_SEL_MEM;
                        c.cond_ld          = 1'b1;
                        c.cond_ld_data_sel = COND_LD_DATA_SEL_RFW;
                    end
                    OP_LEA: begin
                        c.rf_w_en          = 1'b1;
                        c.rf_w_data_sel    = RF_W_DATA_SEL_LEA;
                        c.cond_ld          = 1'b1;
                        c.cond_ld_data_sel = COND_LD_DATA_SEL_RFW;
                    end
                    OP_ST, OP_STR: begin
                        c.mem_w_en       = 1'b1;
                        c.mem_w_addr_sel = (op == OP_ST) ? MEM_W_ADDR_SEL_PCOFF9
                                                         : MEM_W_ADDR_SEL_BASEOFF6;
                        c.rf_r1_addr_sel = RF_R1_ADDR_SEL_SR;
                    end
                    OP_LDI, OP_STI: begin
                        c.mem_r_addr_sel = MEM_R_ADDR_SEL_PCOFF9;
                        c.ptr_ld         = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EXEC2: begin
                if (op == OP_LDI) begin
                    c.mem_r_addr_sel   = MEM_R_ADDR_SEL_INDIRECT;
                    c.rf_w_en          = 1'b1;
                    c.rf_w_data_sel    = RF_W_DATA_SEL_MEM;
                    c.cond_ld          = 1'b1;
                    c.cond_ld_data_sel = COND_LD_DATA_SEL_RFW;
                end else if (op == OP_STI) begin
                    c.mem_w_en       = 1'b1;
                    c.mem_w_addr_sel = MEM_W_ADDR_SEL_INDIRECT;
                    c.rf_r1_addr_sel = RF_R1_ADDR_SEL_SR;
                end
            end
            default: ;
        endcase
        ctrl_o = c;
    end

endmodule

// File: rtl/punc_control.sv
// PUnC multi-cycle control FSM. Define PUNC_ILLEGAL_TRAP_EN to halt on the
// reserved opcodes and expose the sticky illegal_op flag.
module punc_control
    import punc_pkg::*;
#(
    parameter logic [7:0] HALT_VEC = 8'h25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ir,
    input  logic              n,
    input  logic              z,
    input  logic              p,
    output logic [CTRL_W-1:0] ctrl,
    output logic              halted
`ifdef PUNC_ILLEGAL_TRAP_EN
    ,
    output logic              illegal_op
`endif
);

    state_t     state_q, state_d;
    logic       halted_q;
    logic [3:0] op;
    logic       trap_halt;
    logic       rsvd_halt;
    ctrl_t      ctrl_w;

    assign op        = ir[15:12];
    assign trap_halt = (op == OP_TRAP) && (ir[7:0] == HALT_VEC);

`ifdef PUNC_ILLEGAL_TRAP_EN
    assign rsvd_halt = (op == OP_RSV8) || (op == OP_RSVD);
`else
    assign rsvd_halt = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (is_indirect(op))             state_d = S_EXEC2;
                else if (trap_halt || rsvd_halt) state_d = S_HALT;
                else                             state_d = S_FETCH;
            end
            S_EXEC2:  state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_INIT;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == S_HALT);
        end
    end

    assign halted = halted_q;

`ifdef PUNC_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) illegal_q <= 1'b0;
        else      illegal_q <= illegal_q | ((state_q == S_EXEC) && rsvd_halt);
    end

    assign illegal_op = illegal_q;
`endif

    punc_decode u_decode (
        .state_i (state_q),
        .ir_i    (ir),
        .n_i     (n),
        .z_i     (z),
        .p_i     (p),
        .ctrl_o  (ctrl_w)
    );

    assign ctrl = ctrl_w;

endmodule

// File: tb/tb_punc_control.sv
// Scoreboard bench for punc_control: an instruction-level model queues the
// expected per-cycle control words, a negedge monitor compares them.
module tb_punc_control;
    import punc_pkg::*;

    localparam logic [7:0] HALT_VEC = 8'h25;
`ifdef PUNC_ILLEGAL_TRAP_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    typedef logic [CTRL_W+1:0] obs_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       ir;
    logic              n, z, p;
    logic [CTRL_W-1:0] ctrl;
    logic              halted;
    logic              ill_obs;

    punc_control #(.HALT_VEC(HALT_VEC)) dut (
        .clk    (clk),
        .rst    (rst),
        .ir     (ir),
        .n      (n),
        .z      (z),
        .p      (p),
        .ctrl   (ctrl),
        .halted (halted)
`ifdef PUNC_ILLEGAL_TRAP_EN
        ,
        .illegal_op (ill_obs)
`endif
    );

`ifndef PUNC_ILLEGAL_TRAP_EN
    assign ill_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    mon_en  = 1'b0;

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ill/halt/ctrl=%h expected %h", name, act, exp);
        end
    endtask

    function automatic ctrl_t init_word();
        ctrl_t w;
        w = '0;
        w.pc_clr = 1'b1;
        return w;
    endfunction

    function automatic ctrl_t fetch_word();
        ctrl_t w;
        w = '0;
        w.ir_ld  = 1'b1;
        w.pc_inc = 1'b1;
        w.mem_r_addr_sel = MEM_R_ADDR_SEL_PC;
        return w;
    endfunction

    // Instruction-level reference: what each opcode asks of the datapath.
    function automatic ctrl_t model_exec(input logic [15:0] i, input logic [2:0] nzp_v,
                                         input bit second);
        ctrl_t      w;
        logic [3:0] op;
        w  = '0;
        op = i[15:12];
        if (second) begin
            if (op == OP_LDI) begin
                w.mem_r_addr_sel   = MEM_R_ADDR_SEL_INDIRECT;
                w.rf_w_en          = 1'b1;
                w.rf_w_data_sel    = RF_W_DATA_SEL_MEM;
                w.cond_ld          = 1'b1;
                w.cond_ld_data_sel = COND_LD_DATA_SEL_RFW;
            end else begin
                w.mem_w_en       = 1'b1;
                w.mem_w_addr_sel = MEM_W_ADDR_SEL_INDIRECT;
                w.rf_r1_addr_sel = RF_R1_ADDR_SEL_SR;
            end
            return w;
        end
        if (op inside {OP_ADD, OP_AND, OP_NOT}) begin
            w.rf_w_en = 1'b1;
            w.cond_ld = 1'b1;
        end
        if (op inside {OP_LD, OP_LDR, OP_LEA}) begin
            w.rf_w_en          = 1'b1;
            w.cond_ld          = 1'b1;
            w.cond_ld_data_sel = COND_LD_DATA_SEL_RFW;
            w.rf_w_data_sel    = (op == OP_LEA) ? RF_W_DATA_SEL_LEA : RF_W_DATA_SEL_MEM;
        end
        if (op == OP_AND) w.alu_fn = ALU_FN_AND;
        if (op == OP_NOT) w.alu_fn = ALU_FN_NOT;
        if (op inside {OP_ADD, OP_AND}) w.alu_imm = i[5];
        if (op == OP_LD)  w.mem_r_addr_sel = MEM_R_ADDR_SEL_PCOFF9;
        if (op == OP_LDR) w.mem_r_addr_sel = MEM_R_ADDR_SEL_BASEOFF6;
        if (op inside {OP_LDI, OP_STI}) begin
            w.mem_r_addr_sel = MEM_R_ADDR_SEL_PCOFF9;
            w.ptr_ld         = 1'b1;
        end
        if (op inside {OP_ST, OP_STR}) begin
            w.mem_w_en       = 1'b1;
            w.rf_r1_addr_sel = RF_R1_ADDR_SEL_SR;
            w.mem_w_addr_sel = (op == OP_ST) ? MEM_W_ADDR_SEL_PCOFF9 : MEM_W_ADDR_SEL_BASEOFF6;
        end
        if (op == OP_BR && (i[11:9] & nzp_v) != 3'b000) w.pc_ld = 1'b1;
        if (op == OP_JMP) begin
            w.pc_ld          = 1'b1;
            w.pc_ld_data_sel = PC_LD_DATA_SEL_BASE;
        end
        if (op == OP_JSR) begin
            w.rf_w_en        = 1'b1;
            w.rf_w_addr_sel  = RF_W_ADDR_SEL_R7;
            w.rf_w_data_sel  = RF_W_DATA_SEL_PC;
            w.pc_ld          = 1'b1;
            w.pc_ld_data_sel = i[11] ? PC_LD_DATA_SEL_PCOFF11 : PC_LD_DATA_SEL_BASE;
        end
        return w;
    endfunction

    task automatic push_exp(input string tag, input logic ill, input logic hlt, input ctrl_t w);
        exp_q.push_back({ill, hlt, w});
        tag_q.push_back(tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        push_exp("reset_held", 1'b0, 1'b0, init_word());
        step();
        rst = 1'b1;
        push_exp("init", 1'b0, 1'b0, init_word());
        step();
    endtask

    // Called at the start of a FETCH cycle; runs the instruction to completion.
    task automatic run_instr(input logic [15:0] i, input logic [2:0] nzp_v);
        logic [3:0] op;
        bit         stops;
        int         len;
        op = i[15:12];
        ir = i;
        {n, z, p} = nzp_v;
        push_exp($sformatf("fetch_%h", i), 1'b0, 1'b0, fetch_word());
        push_exp($sformatf("decode_%h", i), 1'b0, 1'b0, '0);
        push_exp($sformatf("exec_%h_nzp%b", i, nzp_v), 1'b0, 1'b0, model_exec(i, nzp_v, 1'b0));
        len = 3;
        if (op inside {OP_LDI, OP_STI}) begin
            push_exp($sformatf("exec2_%h", i), 1'b0, 1'b0, model_exec(i, nzp_v, 1'b1));
            len = 4;
        end
        stops = (op == OP_TRAP && i[7:0] == HALT_VEC) || (ILL && op inside {OP_RSV8, OP_RSVD});
        if (stops) begin
            repeat (20) push_exp($sformatf("halt_%h", i), op != OP_TRAP, 1'b1, '0);
            len += 20;
        end
        repeat (len) step();
        if (stops) do_reset();
    endtask

    task automatic st_reset_test();
        ir = 16'h3A05;
        {n, z, p} = 3'b001;
        push_exp("fetch_st", 1'b0, 1'b0, fetch_word());
        push_exp("decode_st", 1'b0, 1'b0, '0);
        push_exp("exec_st", 1'b0, 1'b0, model_exec(16'h3A05, 3'b001, 1'b0));
        repeat (2) step();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid_exec_st", {ill_obs, halted, ctrl}, {1'b0, 1'b0, init_word()});
        step();
        do_reset();
    endtask

    always @(negedge clk) begin
        obs_t  e;
        string t;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL underflow: got ill/halt/ctrl=%h with no expected entry",
                         {ill_obs, halted, ctrl});
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, {ill_obs, halted, ctrl}, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        ir  = 16'h0000;
        {n, z, p} = 3'b000;
        repeat (2) step();
        mon_en = 1'b1;
        do_reset();

        run_instr(16'h1042, 3'b000);   // ADD R0,R1,R2
        run_instr(16'h1061, 3'b100);   // ADD R0,R1,#1
        run_instr(16'h5A3F, 3'b001);   // AND imm
        run_instr(16'h903F, 3'b010);   // NOT
        run_instr(16'h0405, 3'b010);   // BRz taken
        run_instr(16'h0405, 3'b100);   // BRz not taken
        run_instr(16'h0005, 3'b111);   // nzp field 000 never branches
        run_instr(16'h0E05, 3'b001);   // BRnzp taken
        run_instr(16'h4803, 3'b000);   // JSR PC+sext11
        run_instr(16'h4080, 3'b000);   // JSRR base
        run_instr(16'hC1C0, 3'b000);   // JMP
        run_instr(16'hB002, 3'b000);   // STI
        run_instr(16'hA002, 3'b000);   // LDI
        run_instr(16'h2203, 3'b000);   // LD
        run_instr(16'h6443, 3'b000);   // LDR
        run_instr(16'hE3FF, 3'b000);   // LEA
        run_instr(16'h3605, 3'b000);   // ST
        run_instr(16'h7845, 3'b000);   // STR
        run_instr(16'hF020, 3'b000);   // TRAP non-halt is a NOP
        run_instr(16'h8000, 3'b000);   // reserved
        st_reset_test();
        run_instr(16'hD000, 3'b000);   // reserved
        run_instr(16'h1042, 3'b000);
        run_instr(16'hF025, 3'b000);   // HALT
        run_instr(16'h1042, 3'b000);

        for (int k = 0; k < 150; k++) begin
            run_instr(16'($urandom), 3'($urandom));
        end

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d unconsumed entries expected 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
